crash_fuel_sequencer: RTL and testbench

//  Game-level sequencer that consumes per-frame collision flags from the collision manager.
//  - collisions[0]: player hit an AI car.
//  - collisions[1]: player hit a fuel pickup.

---
 rtl/crash_fuel_sequencer.sv | 169 ++++++++++++++++
 tb/tb_crash_fuel_sequencer.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/crash_fuel_sequencer.sv
// Player crash/respawn sequencer and fuel tank, advanced once per video frame.
// Consumes per-frame collision flags and drives steering, blink, HUD fuel and game-over.
module crash_fuel_sequencer #(
  parameter int CRASH_FRAMES      = 60,
  parameter int GRACE_FRAMES      = 90,
  parameter int BLINK_PERIOD      = 8,
  parameter int FUEL_MAX          = 100,
  parameter int FUEL_BONUS        = 20,
  parameter int FUEL_DECAY_FRAMES = 30,
  parameter int FUEL_W            = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_start,
  input  logic [1:0]        collisions,
  input  logic              game_start,
  output logic              player_enable,
  output logic              player_visible,
  output logic              crash_pulse,
  output logic [FUEL_W-1:0] fuel_level,
  output logic              game_over,
  output logic [7:0]        crash_count
);

  localparam int FRAME_MAX = (CRASH_FRAMES > GRACE_FRAMES) ? CRASH_FRAMES : GRACE_FRAMES;
  localparam int BLINK_BIT = $clog2(BLINK_PERIOD);
  localparam int FRAME_W   = ($clog2(FRAME_MAX + 1) > BLINK_BIT + 1) ? $clog2(FRAME_MAX + 1) : BLINK_BIT + 1;
  localparam int DECAY_W   = $clog2(FUEL_DECAY_FRAMES + 1);
  localparam int SUM_W     = FUEL_W + 1;

  localparam logic [FRAME_W-1:0] CRASH_LAST = FRAME_W'(CRASH_FRAMES - 1);
  localparam logic [FRAME_W-1:0] GRACE_LAST = FRAME_W'(GRACE_FRAMES - 1);
  localparam logic [FRAME_W-1:0] FRAME_ONE  = FRAME_W'(1);
  localparam logic [DECAY_W-1:0] DECAY_LAST = DECAY_W'(FUEL_DECAY_FRAMES - 1);
  localparam logic [DECAY_W-1:0] DECAY_ONE  = DECAY_W'(1);
  localparam logic [SUM_W-1:0]   SUM_MAX    = SUM_W'(FUEL_MAX);
  localparam logic [SUM_W-1:0]   SUM_BONUS  = SUM_W'(FUEL_BONUS);
  localparam logic [SUM_W-1:0]   SUM_ONE    = SUM_W'(1);
  localparam logic [FUEL_W-1:0]  FUEL_FULL  = FUEL_W'(FUEL_MAX);

  typedef enum logic [2:0] {
    ST_READY,
    ST_DRIVE,
    ST_CRASH,
    ST_GRACE,
    ST_GAME_OVER
  } state_t;

  state_t              state, state_nxt;
  logic [FRAME_W-1:0]  frame_cnt, frame_cnt_nxt;
  logic [DECAY_W-1:0]  decay_cnt, decay_cnt_nxt;
  logic [FUEL_W-1:0]   fuel_nxt;
  logic [7:0]          crash_count_nxt;
  logic [1:0]          prev_col, prev_col_nxt;
  logic [1:0]          rise;
  logic                pulse_nxt;
  logic                active;
  logic                burn;
  logic                pickup;
  logic [SUM_W-1:0]    fuel_burned;
  logic [SUM_W-1:0]    fuel_sum;

  // Next-state logic: a restart from an idle state takes precedence over any frame work.
  always_comb begin
    state_nxt       = state;
    frame_cnt_nxt   = frame_cnt;
    decay_cnt_nxt   = decay_cnt;
    fuel_nxt        = fuel_level;
    crash_count_nxt = crash_count;
    prev_col_nxt    = prev_col;
    pulse_nxt       = 1'b0;
    rise            = collisions & ~prev_col;
    active          = (state == ST_DRIVE) || (state == ST_CRASH) || (state == ST_GRACE);
    burn            = 1'b0;
    pickup          = 1'b0;
    fuel_burned     = {1'b0, fuel_level};
    fuel_sum        = {1'b0, fuel_level};

    if (((state == ST_READY) || (state == ST_GAME_OVER)) && game_start) begin
      state_nxt       = ST_DRIVE;
      frame_cnt_nxt   = '0;
      decay_cnt_nxt   = '0;
      fuel_nxt        = FUEL_FULL;
      crash_count_nxt = '0;
      prev_col_nxt    = '0;
    end else if (frame_start) begin
      prev_col_nxt = collisions;
      if (active) begin
        burn          = (decay_cnt == DECAY_LAST);
        decay_cnt_nxt = burn ? '0 : decay_cnt + DECAY_ONE;
        if (burn && (fuel_level != '0)) begin
          fuel_burned = {1'b0, fuel_level} - SUM_ONE;
        end
        pickup   = rise[1] && (state != ST_CRASH);
        fuel_sum = pickup ? fuel_burned + SUM_BONUS : fuel_burned;
        if (fuel_sum > SUM_MAX) begin
          fuel_sum = SUM_MAX;
        end
        fuel_nxt = fuel_sum[FUEL_W-1:0];

        // An empty tank ends the game and suppresses any crash in the same frame.
        if (fuel_sum == '0) begin
          state_nxt = ST_GAME_OVER;
        end else begin
          case (state)
            ST_DRIVE: begin
              if (rise[0]) begin
                state_nxt     = ST_CRASH;
                frame_cnt_nxt = '0;
                pulse_nxt     = 1'b1;
                if (crash_count != 8'hFF) begin
                  crash_count_nxt = crash_count + 8'd1;
                end
              end
            end
            ST_CRASH: begin
              if (frame_cnt == CRASH_LAST) begin
                state_nxt     = ST_GRACE;
                frame_cnt_nxt = '0;
              end else begin
                frame_cnt_nxt = frame_cnt + FRAME_ONE;
              end
            end
            ST_GRACE: begin
              if (frame_cnt == GRACE_LAST) begin
                state_nxt     = ST_DRIVE;
                frame_cnt_nxt = '0;
              end else begin
                frame_cnt_nxt = frame_cnt + FRAME_ONE;
              end
            end
            default: begin
              state_nxt = state;
            end
          endcase
        end
      end
    end
  end

  // State, counters and registered outputs; outputs are decoded from the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= ST_READY;
      frame_cnt      <= '0;
      decay_cnt      <= '0;
      fuel_level     <= FUEL_FULL;
      crash_count    <= '0;
      prev_col       <= '0;
      player_enable  <= 1'b0;
      player_visible <= 1'b1;
      crash_pulse    <= 1'b0;
      game_over      <= 1'b0;
    end else begin
      state          <= state_nxt;
      frame_cnt      <= frame_cnt_nxt;
      decay_cnt      <= decay_cnt_nxt;
      fuel_level     <= fuel_nxt;
      crash_count    <= crash_count_nxt;
      prev_col       <= prev_col_nxt;
      player_enable  <= (state_nxt == ST_DRIVE) || (state_nxt == ST_GRACE);
      player_visible <= ((state_nxt == ST_CRASH) || (state_nxt == ST_GRACE)) ?
                        ~frame_cnt_nxt[BLINK_BIT] : 1'b1;
      crash_pulse    <= pulse_nxt;
      game_over      <= (state_nxt == ST_GAME_OVER);
    end
  end

endmodule

// File: tb/tb_crash_fuel_sequencer.sv
// Self-checking bench for crash_fuel_sequencer: frame-level reference model,
// per-cycle comparison, directed scenarios and a randomized soak.
module tb_crash_fuel_sequencer;

  localparam int CRASH_N = 60;
  localparam int GRACE_N = 90;
  localparam int BLINK_N = 8;
  localparam int FULL    = 100;
  localparam int BONUS   = 20;
  localparam int DECAY_N = 30;

  typedef enum int {M_READY, M_DRIVE, M_CRASH, M_GRACE, M_OVER} mode_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       frame_start = 1'b0;
  logic [1:0] collisions = 2'b00;
  logic       game_start = 1'b0;
  logic       player_enable;
  logic       player_visible;
  logic       crash_pulse;
  logic [6:0] fuel_level;
  logic       game_over;
  logic [7:0] crash_count;

  int total = 0;
  int bad = 0;
  int pulse_seen = 0;
  bit cmp_en = 1'b0;

  mode_t      m_mode;
  int         m_fuel, m_frames, m_ticks, m_crashes;
  logic [1:0] m_prev;
  bit         m_pulse;

  crash_fuel_sequencer dut (
    .clk(clk),
    .reset(reset),
    .frame_start(frame_start),
    .collisions(collisions),
    .game_start(game_start),
    .player_enable(player_enable),
    .player_visible(player_visible),
    .crash_pulse(crash_pulse),
    .fuel_level(fuel_level),
    .game_over(game_over),
    .crash_count(crash_count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // One video frame: a single-cycle frame_start, returning on the negedge after its edge.
  task automatic applyStimulus(input logic [1:0] col);
    @(negedge clk);
    frame_start = 1'b1;
    collisions  = col;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic startGame();
    @(negedge clk);
    game_start = 1'b1;
    @(negedge clk);
    game_start = 1'b0;
  endtask

  task automatic syncReset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Reference model: game rules expressed per frame in plain integer arithmetic.
  always @(posedge clk or posedge reset) begin : ref_model
    automatic mode_t      mode;
    automatic int         fuel, frames, ticks, crashes;
    automatic logic [1:0] rise;
    automatic bit         pulse;
    if (reset) begin
      m_mode    <= M_READY;
      m_fuel    <= FULL;
      m_frames  <= 0;
      m_ticks   <= 0;
      m_crashes <= 0;
      m_prev    <= 2'b00;
      m_pulse   <= 1'b0;
    end else begin
      mode    = m_mode;
      fuel    = m_fuel;
      frames  = m_frames;
      ticks   = m_ticks;
      crashes = m_crashes;
      pulse   = 1'b0;
      if ((mode == M_READY || mode == M_OVER) && game_start) begin
        mode    = M_DRIVE;
        fuel    = FULL;
        frames  = 0;
        ticks   = 0;
        crashes = 0;
        m_prev  <= 2'b00;
      end else if (frame_start) begin
        rise = collisions & ~m_prev;
        m_prev <= collisions;
        if (mode == M_DRIVE || mode == M_CRASH || mode == M_GRACE) begin
          ticks = ticks + 1;
          if (ticks == DECAY_N) begin
            ticks = 0;
            fuel  = (fuel > 0) ? fuel - 1 : 0;
          end
          if (rise[1] && mode != M_CRASH) fuel = (fuel + BONUS > FULL) ? FULL : fuel + BONUS;
          if (fuel == 0) begin
            mode = M_OVER;
          end else if (mode == M_DRIVE) begin
            if (rise[0]) begin
              mode    = M_CRASH;
              frames  = 0;
              pulse   = 1'b1;
              crashes = (crashes < 255) ? crashes + 1 : 255;
            end
          end else begin
            frames = frames + 1;
            if (mode == M_CRASH && frames == CRASH_N) begin
              mode   = M_GRACE;
              frames = 0;
            end else if (mode == M_GRACE && frames == GRACE_N) begin
              mode   = M_DRIVE;
              frames = 0;
            end
          end
        end
      end
      m_mode    <= mode;
      m_fuel    <= fuel;
      m_frames  <= frames;
      m_ticks   <= ticks;
      m_crashes <= crashes;
      m_pulse   <= pulse;
    end
  end

  // Every cycle outside reset, all outputs are compared against the model.
  always @(negedge clk) begin
    if (cmp_en && !reset) begin
      checkOutput("enable", player_enable, (m_mode == M_DRIVE || m_mode == M_GRACE) ? 1 : 0);
      checkOutput("visible", player_visible,
                  (m_mode == M_CRASH || m_mode == M_GRACE) ? (((m_frames / BLINK_N) % 2 == 0) ? 1 : 0) : 1);
      checkOutput("pulse", crash_pulse, m_pulse);
      checkOutput("fuel", fuel_level, m_fuel);
      checkOutput("game_over", game_over, (m_mode == M_OVER) ? 1 : 0);
      checkOutput("crash_count", crash_count, m_crashes);
      if (crash_pulse) pulse_seen++;
    end
  end

  initial begin : watchdog
    #5000000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    int n;
    int base;
    #2 reset = 1'b1;
    #20;
    // Reset values
    checkOutput("rst_enable", player_enable, 0);
    checkOutput("rst_visible", player_visible, 1);
    checkOutput("rst_pulse", crash_pulse, 0);
    checkOutput("rst_fuel", fuel_level, 100);
    checkOutput("rst_game_over", game_over, 0);
    checkOutput("rst_crash_count", crash_count, 0);
    @(negedge clk);
    reset  = 1'b0;
    cmp_en = 1'b1;

    // Start and a held AI hit that must count once
    startGame();
    checkOutput("start_enable", player_enable, 1);
    checkOutput("start_fuel", fuel_level, 100);
    applyStimulus(2'b01);
    checkOutput("hit_pulse", crash_pulse, 1);
    checkOutput("hit_count", crash_count, 1);
    applyStimulus(2'b01);
    applyStimulus(2'b01);
    checkOutput("held_pulses", pulse_seen, 1);
    checkOutput("held_count", crash_count, 1);
    for (int i = 0; i < 5; i++) applyStimulus(2'b00);
    checkOutput("blink_on", player_visible, 1);
    applyStimulus(2'b00);
    checkOutput("blink_off", player_visible, 0);
    for (int i = 0; i < 51; i++) applyStimulus(2'b00);
    checkOutput("crash_frozen", player_enable, 0);
    applyStimulus(2'b00);
    checkOutput("grace_enable", player_enable, 1);
    checkOutput("grace_visible", player_visible, 1);
    applyStimulus(2'b01);
    for (int i = 0; i < 88; i++) applyStimulus(2'b00);
    checkOutput("grace_hit_ignored", pulse_seen, 1);
    checkOutput("grace_blink_last", player_visible, 0);
    applyStimulus(2'b00);
    checkOutput("drive_visible", player_visible, 1);
    checkOutput("drive_enable", player_enable, 1);

    // Fuel burn down to game over
    syncReset();
    startGame();
    for (int i = 0; i < 29; i++) applyStimulus(2'b00);
    checkOutput("fuel_29", fuel_level, 100);
    applyStimulus(2'b00);
    checkOutput("fuel_30", fuel_level, 99);
    n = 0;
    while (!game_over && n < 3100) begin
      applyStimulus(2'b00);
      n++;
    end
    checkOutput("empty_frames", n + 30, 3000);
    checkOutput("empty_over", game_over, 1);
    checkOutput("empty_fuel", fuel_level, 0);
    checkOutput("empty_enable", player_enable, 0);
    startGame();
    checkOutput("restart_fuel", fuel_level, 100);
    checkOutput("restart_over", game_over, 0);

    // Pickups with clamping, and a pickup ignored during a crash
    n = 0;
    while (fuel_level != 7'd50 && n < 1600) begin
      applyStimulus(2'b00);
      n++;
    end
    checkOutput("reach_50", fuel_level, 50);
    applyStimulus(2'b10);
    checkOutput("pickup_50", fuel_level, 70);
    applyStimulus(2'b00);
    applyStimulus(2'b10);
    checkOutput("pickup_70", fuel_level, 90);
    applyStimulus(2'b00);
    applyStimulus(2'b10);
    checkOutput("pickup_clamp", fuel_level, 100);
    applyStimulus(2'b01);
    applyStimulus(2'b10);
    checkOutput("pickup_in_crash", fuel_level, 100);
    checkOutput("pickup_in_crash_en", player_enable, 0);

    // Simultaneous pickup and crash, then a crash on the last drop of fuel
    syncReset();
    startGame();
    n = 0;
    while (fuel_level != 7'd50 && n < 1600) begin
      applyStimulus(2'b00);
      n++;
    end
    applyStimulus(2'b11);
    checkOutput("both_fuel", fuel_level, 70);
    checkOutput("both_pulse", crash_pulse, 1);
    checkOutput("both_enable", player_enable, 0);
    n = 0;
    while (fuel_level != 7'd1 && n < 2300) begin
      applyStimulus(2'b00);
      n++;
    end
    checkOutput("reach_1", fuel_level, 1);
    for (int i = 0; i < 29; i++) applyStimulus(2'b00);
    base = pulse_seen;
    applyStimulus(2'b01);
    checkOutput("last_drop_over", game_over, 1);
    checkOutput("last_drop_pulse", crash_pulse, 0);
    checkOutput("last_drop_count", crash_count, 1);
    applyStimulus(2'b00);
    checkOutput("last_drop_no_pulse", pulse_seen, base);

    // Randomized soak, including game_start coinciding with frame_start
    for (int i = 0; i < 8000; i++) begin
      @(negedge clk);
      frame_start = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 5) == 0) collisions[0] = ~collisions[0];
      if ($urandom_range(0, 7) == 0) collisions[1] = ~collisions[1];
      game_start = ($urandom_range(0, 149) == 0);
    end
    @(negedge clk);
    frame_start = 1'b0;
    game_start  = 1'b0;

    // Asynchronous reset mid-crash
    syncReset();
    startGame();
    applyStimulus(2'b01);
    for (int i = 0; i < 9; i++) applyStimulus(2'b00);
    checkOutput("mid_crash_visible", player_visible, 0);
    checkOutput("mid_crash_count", crash_count, 1);
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    checkOutput("async_enable", player_enable, 0);
    checkOutput("async_visible", player_visible, 1);
    checkOutput("async_pulse", crash_pulse, 0);
    checkOutput("async_fuel", fuel_level, 100);
    checkOutput("async_over", game_over, 0);
    checkOutput("async_count", crash_count, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
